bcd_word_checker: RTL

//   Multi-digit BCD legality checker with valid/ready handshakes on both sides.

---
 rtl/bcd_word_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bcd_word_checker.sv
// -----------------------------------------------------------------------------
// bcd_word_checker
//   Multi-digit BCD legality checker with valid/ready handshakes on both sides.
//   The checker captures one word of DIGITS 4-bit digits and then scans it one
//   digit per clock. A digit is legal when its value is <= MAX_DIGIT.
//   The results are:
//     - a per-digit legality mask
//     - an overall OK flag
//     - the index of the lowest illegal digit
//
//   Optional feature macro: BCD_ERRCNT_EN
//     When this macro is defined, the err_count port exists. It is a saturating
//     count of the output handshakes whose word had out_ok = 0.
//
// Ports
//   clk            in   1          rising-edge clock
//   rst_n          in   1          synchronous reset, active low
//   in_valid       in   1          in_data is valid
//   in_ready       out  1          checker can accept a word (IDLE)
//   in_data        in   4*DIGITS   digit i = in_data[4i+3:4i], digit 0 = LS nibble
//   out_valid      out  1          result is valid (DONE)
//   out_ready      in   1          downstream accepts the result
//   out_ok         out  1          all digits legal (= &out_mask)
//   out_mask       out  DIGITS     bit i set when digit i is legal
//   out_first_bad  out  IDX_W      lowest illegal digit index, 0 when out_ok = 1
//   err_count      out  CNT_W      words handed off with out_ok = 0
//                                  (present only with BCD_ERRCNT_EN)
// -----------------------------------------------------------------------------
module bcd_word_checker #(
  parameter int DIGITS    = 4,
  parameter int MAX_DIGIT = 9,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_ok,
  output logic [DIGITS-1:0]     out_mask,
  output logic [IDX_W-1:0]      out_first_bad
`ifdef BCD_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]      err_count
`endif
);

  localparam logic [3:0]       MAX_D    = 4'(MAX_DIGIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic                  found_q, found_d;
  logic [IDX_W-1:0]      first_bad_q, first_bad_d;

  // Legality of every captured digit. The scan below picks one digit per cycle,
  // so the mask still builds up over DIGITS cycles as intended.
  logic [DIGITS-1:0]     legal;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_legal
    assign legal[gi] = (data_q[4*gi +: 4] <= MAX_D);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      found_q     <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      found_q     <= found_d;
      first_bad_q <= first_bad_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    found_d     = found_q;
    first_bad_d = first_bad_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d      = in_data;
          idx_d       = '0;
          mask_d      = '0;
          found_d     = 1'b0;
          // Clearing here keeps first_bad at 0 for an all-legal word.
          first_bad_d = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        mask_d[idx_q] = legal[idx_q];
        // Only the first illegal digit records its index.
        if (!legal[idx_q] && !found_q) begin
          found_d     = 1'b1;
          first_bad_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        // There is no DONE->SCAN bypass. A new word is taken only from IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_mask      = mask_q;
  assign out_ok        = &mask_q;
  assign out_first_bad = first_bad_q;

`ifdef BCD_ERRCNT_EN
  logic [CNT_W-1:0] err_q, err_d;

  // Saturating counter of handshakes whose word held an illegal digit.
  always_comb begin
    err_d = err_q;
    if (out_valid && out_ready && !out_ok && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule
